// File: rtl/jtkiwi_gfxrom_pkg.sv
// Shared types and constants for the jtkiwi graphics ROM arbiter.
package jtkiwi_gfxrom_pkg;

  localparam int ADDR_W   = 18;  // client address bits [19:2]
  localparam int SDRAM_AW = 22;  // SDRAM 16-bit-word address width
  localparam int DATA_W   = 32;
  localparam int NCLIENT  = 2;

  // Client indices
  localparam int SCR = 0;
  localparam int OBJ = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } state_t;

endpackage

// File: rtl/jtkiwi_gfxrom_slot.sv
// One client slot: latched address, data register and valid flag.
// ok is combinational so a repeated address hits in the same cycle.
module jtkiwi_gfxrom_slot
  import jtkiwi_gfxrom_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              latch,
  input  logic              store,
  input  logic [DATA_W-1:0] din,
  output logic              ok,
  output logic              pending,
  output logic [DATA_W-1:0] data
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // Next-state: latch clears valid for a new fetch, store fills and validates
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (latch) begin
      addr_d  = addr;
      valid_d = 1'b0;
    end
    if (store) begin
      data_d  = din;
      valid_d = 1'b1;
    end
  end

  // Slot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign ok      = cs & valid_q & (addr == addr_q);
  assign pending = cs & ~ok;
  assign data    = data_q;

endmodule

// File: rtl/jtkiwi_gfxrom.sv
// Graphics ROM arbiter: two 32-bit clients (tiles, sprites) sharing one
// SDRAM read port. Optional macro JTKIWI_GFXROM_RR_EN selects round-robin
// tie breaking; without it the tile client always wins ties.
module jtkiwi_gfxrom
  import jtkiwi_gfxrom_pkg::*;
#(
  parameter logic [21:0] SCR_OFFSET = 22'h00_0000,
  parameter logic [21:0] OBJ_OFFSET = 22'h10_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scr_cs,
  input  logic [19:2] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [19:2] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [31:0] sdram_din
);

  logic [NCLIENT-1:0] cs_a, ok_a, pend_a, latch_a, store_a;
  logic [ADDR_W-1:0]  addr_a [NCLIENT];
  logic [DATA_W-1:0]  data_a [NCLIENT];

  assign cs_a[SCR]   = scr_cs;
  assign cs_a[OBJ]   = obj_cs;
  assign addr_a[SCR] = scr_addr;
  assign addr_a[OBJ] = obj_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NCLIENT; gi++) begin : g_slot
      jtkiwi_gfxrom_slot u_slot (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs_a[gi]),
        .addr    (addr_a[gi]),
        .latch   (latch_a[gi]),
        .store   (store_a[gi]),
        .din     (sdram_din),
        .ok      (ok_a[gi]),
        .pending (pend_a[gi]),
        .data    (data_a[gi])
      );
    end
  endgenerate

  assign scr_ok   = ok_a[SCR];
  assign obj_ok   = ok_a[OBJ];
  assign scr_data = data_a[SCR];
  assign obj_data = data_a[OBJ];

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] sdram_addr_q, sdram_addr_d;
  logic                pick;

`ifdef JTKIWI_GFXROM_RR_EN
  // ptr names the client preferred on the next tie
  logic ptr_q, ptr_d;

  // Tie goes to ptr; otherwise whichever client is pending
  always_comb begin
    if (pend_a[SCR] && pend_a[OBJ]) pick = ptr_q;
    else                            pick = ~pend_a[SCR];
    ptr_d = ptr_q;
    if (state_q == IDLE && (|pend_a)) ptr_d = ~pick;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: tiles win whenever they are pending
  always_comb begin
    pick = ~pend_a[SCR];
  end
`endif

  // FSM next-state and slot control
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    req_d        = req_q;
    sdram_addr_d = sdram_addr_q;
    latch_a      = '0;
    store_a      = '0;
    case (state_q)
      IDLE: begin
        if (|pend_a) begin
          latch_a[pick] = 1'b1;
          sel_d         = pick;
          req_d         = 1'b1;
          sdram_addr_d  = (pick ? OBJ_OFFSET : SCR_OFFSET)
                          + {3'b000, addr_a[pick], 1'b0};
          state_d       = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          // rdy alongside ack completes the transfer straight away
          if (sdram_rdy) begin
            store_a[sel_q] = 1'b1;
            state_d        = IDLE;
          end else begin
            state_d = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (sdram_rdy) begin
          store_a[sel_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and SDRAM request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      req_q        <= 1'b0;
      sdram_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      req_q        <= req_d;
      sdram_addr_q <= sdram_addr_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jtkiwi_gfxrom.sv
// Self-checking bench for jtkiwi_gfxrom: directed vector table, hand-written
// corner sequences and a randomized run against a per-client cache model.
module tb_jtkiwi_gfxrom;

`ifdef JTKIWI_GFXROM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        scr_cs, obj_cs;
  logic [17:0] scr_addr, obj_addr;
  logic [31:0] scr_data, obj_data;
  logic        scr_ok, obj_ok;
  logic        sdram_req, sdram_ack, sdram_rdy;
  logic [21:0] sdram_addr;
  logic [31:0] sdram_din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtkiwi_gfxrom dut (
    .clk        (clk),
    .rst        (rst),
    .scr_cs     (scr_cs),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_ok     (scr_ok),
    .obj_cs     (obj_cs),
    .obj_addr   (obj_addr),
    .obj_data   (obj_data),
    .obj_ok     (obj_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
  );

  typedef struct {
    int          c;
    logic [17:0] a;
    int          ag;
    int          rg;
    bit          same;
    logic [31:0] din;
    logic [21:0] sa;
  } vec_t;

  vec_t vecs[6];

  // Reference model: last fetched address/data per client
  bit          m_valid[2];
  logic [17:0] m_addr[2];
  logic [31:0] m_data[2];
  logic [17:0] pool[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] exp_addr(input int c, input logic [17:0] a);
    longint unsigned base = (c == 1) ? 64'h10_0000 : 64'h0;
    longint unsigned s    = (base + 2 * longint'(a)) % 64'd4194304;
    return s[21:0];
  endfunction

  function automatic logic cur_ok(input int c);
    return (c == 1) ? obj_ok : scr_ok;
  endfunction

  function automatic logic [31:0] cur_data(input int c);
    return (c == 1) ? obj_data : scr_data;
  endfunction

  task automatic set_client(input int c, input logic cs, input logic [17:0] a);
    if (c == 1) begin
      obj_cs = cs; obj_addr = a;
    end else begin
      scr_cs = cs; scr_addr = a;
    end
  endtask

  // Wait (bounded) for sdram_req; n counts negedges waited
  task automatic wait_req(input string name, output int n, output logic [21:0] a);
    n = 0;
    while (!sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, sdram_req}, 32'd1);
    a = sdram_addr;
  endtask

  // SDRAM side of one transfer; returns on the negedge after rdy is sampled
  task automatic serve(input int c, input logic [31:0] d, input int ag, input int rg, input bit same);
    if (ag > 0) begin
      repeat (ag) @(negedge clk);
      chk("req_hold", {31'd0, sdram_req}, 32'd1);
    end
    sdram_ack = 1'b1;
    if (same) begin
      sdram_rdy = 1'b1;
      sdram_din = d;
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;
    chk("req_drop", {31'd0, sdram_req}, 32'd0);
    if (!same) begin
      repeat (rg) @(negedge clk);
      chk("ok_early", {31'd0, cur_ok(c)}, 32'd0);
      sdram_rdy = 1'b1;
      sdram_din = d;
      @(negedge clk);
      sdram_rdy = 1'b0;
    end
    $display("txn client=%0d sdram_addr=%h din=%h", c, sdram_addr, d);
  endtask

  task automatic quiet(input string name, input int ncyc);
    bit seen = 1'b0;
    repeat (ncyc) begin
      @(negedge clk);
      if (sdram_req) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          n;
    logic [21:0] sa;
    logic [31:0] d;
    int          first;

    rst = 1'b1;
    scr_cs = 0; obj_cs = 0; scr_addr = '0; obj_addr = '0;
    sdram_ack = 0; sdram_rdy = 0; sdram_din = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, sdram_req}, 32'd0);
    chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
    chk("rst_scr_data", scr_data, 32'd0);
    chk("rst_obj_data", obj_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors: miss, exact latency, stored data, then a hit
    vecs[0] = '{0, 18'h00010, 0, 0, 1'b0, 32'hDEADBEEF, 22'h000020};
    vecs[1] = '{1, 18'h00004, 0, 0, 1'b0, 32'hCAFEF00D, 22'h100008};
    vecs[2] = '{0, 18'h00020, 0, 0, 1'b1, 32'h12345678, 22'h000040};
    vecs[3] = '{1, 18'h3FFFF, 2, 3, 1'b0, 32'h0BADC0DE, 22'h17FFFE};
    vecs[4] = '{0, 18'h3FFFF, 1, 0, 1'b1, 32'h55AA55AA, 22'h07FFFE};
    vecs[5] = '{0, 18'h00000, 0, 2, 1'b0, 32'h00000001, 22'h000000};
    for (int i = 0; i < 6; i++) begin
      set_client(1 - vecs[i].c, 1'b0, 18'h0);
      set_client(vecs[i].c, 1'b1, vecs[i].a);
      #1;
      chk("vec_miss_ok", {31'd0, cur_ok(vecs[i].c)}, 32'd0);
      wait_req("vec_req", n, sa);
      chk("vec_req_latency", n, 32'd1);
      chk("vec_sdram_addr", {10'd0, sa}, {10'd0, vecs[i].sa});
      serve(vecs[i].c, vecs[i].din, vecs[i].ag, vecs[i].rg, vecs[i].same);
      chk("vec_ok", {31'd0, cur_ok(vecs[i].c)}, 32'd1);
      chk("vec_data", cur_data(vecs[i].c), vecs[i].din);
      quiet("vec_hit_noreq", 2);
      chk("vec_hit_ok", {31'd0, cur_ok(vecs[i].c)}, 32'd1);
    end

    // Address change while waiting for rdy
    set_client(1, 1'b0, 18'h0);
    set_client(0, 1'b1, 18'h00010);
    wait_req("chg_req", n, sa);
    chk("chg_addr1", {10'd0, sa}, 32'h000020);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    scr_addr  = 18'h00011;
    sdram_rdy = 1'b1;
    sdram_din = 32'h11112222;
    @(negedge clk);
    sdram_rdy = 1'b0;
    chk("chg_ok_low", {31'd0, scr_ok}, 32'd0);
    wait_req("chg_req2", n, sa);
    chk("chg_addr2", {10'd0, sa}, 32'h000022);
    serve(0, 32'h33334444, 0, 0, 1'b0);
    chk("chg_ok", {31'd0, scr_ok}, 32'd1);
    chk("chg_data", scr_data, 32'h33334444);

    // cs dropped mid-fetch: the fetch still completes and validates
    scr_cs = 1'b0;
    set_client(1, 1'b1, 18'h00100);
    wait_req("drop_req", n, sa);
    chk("drop_addr", {10'd0, sa}, 32'h100200);
    obj_cs = 1'b0;
    serve(1, 32'h0F0F0F0F, 1, 1, 1'b0);
    obj_cs = 1'b1;
    #1;
    chk("drop_ok", {31'd0, obj_ok}, 32'd1);
    chk("drop_data", obj_data, 32'h0F0F0F0F);
    quiet("drop_noreq", 2);

    // ack/rdy while idle are ignored
    obj_cs = 1'b0;
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_din = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    scr_cs = 1'b1;
    #1;
    chk("idle_ok", {31'd0, scr_ok}, 32'd1);
    chk("idle_data", scr_data, 32'h33334444);
    quiet("idle_noreq", 2);

    // Ties: last served obj, so scr wins the first tie in either mode
    scr_cs = 1'b0;
    set_client(1, 1'b1, 18'h00200);
    wait_req("tie_pre_req", n, sa);
    serve(1, 32'h20202020, 0, 0, 1'b0);
    set_client(0, 1'b1, 18'h00300);
    set_client(1, 1'b1, 18'h00004);
    wait_req("tie1_req_a", n, sa);
    chk("tie1_first", {10'd0, sa}, 32'h000600);
    serve(0, 32'h30303030, 0, 0, 1'b0);
    wait_req("tie1_req_b", n, sa);
    chk("tie1_second", {10'd0, sa}, 32'h100008);
    serve(1, 32'h40404040, 0, 0, 1'b0);
    chk("tie1_ok", {30'd0, scr_ok, obj_ok}, 32'd3);
    // Last served scr: round-robin hands the next tie to obj
    obj_cs = 1'b0;
    set_client(0, 1'b1, 18'h00400);
    wait_req("tie_mid_req", n, sa);
    serve(0, 32'h50505050, 0, 0, 1'b0);
    set_client(0, 1'b1, 18'h00500);
    set_client(1, 1'b1, 18'h00600);
    first = RR ? 1 : 0;
    wait_req("tie2_req_a", n, sa);
    chk("tie2_first", {10'd0, sa}, {10'd0, exp_addr(first, first == 1 ? 18'h00600 : 18'h00500)});
    serve(first, 32'h60606060, 0, 0, 1'b0);
    wait_req("tie2_req_b", n, sa);
    chk("tie2_second", {10'd0, sa}, {10'd0, exp_addr(1 - first, first == 1 ? 18'h00500 : 18'h00600)});
    serve(1 - first, 32'h70707070, 0, 0, 1'b0);
    chk("tie2_data_first", cur_data(first), 32'h60606060);
    chk("tie2_data_second", cur_data(1 - first), 32'h70707070);

    // Reset in WAIT_RDY abandons the fetch
    set_client(0, 1'b1, 18'h00030);
    wait_req("rst_req_a", n, sa);
    chk("rst_fetch_addr", {10'd0, sa}, 32'h000060);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    chk("pre_rst_obj_ok", {31'd0, obj_ok}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, sdram_req}, 32'd0);
    chk("mid_rst_ok", {30'd0, scr_ok, obj_ok}, 32'd0);
    chk("mid_rst_addr", {10'd0, sdram_addr}, 32'd0);
    @(negedge clk);
    scr_cs = 1'b0; obj_cs = 1'b0; rst = 1'b0;
    @(negedge clk);
    sdram_rdy = 1'b1; sdram_din = 32'hAAAA5555;
    @(negedge clk);
    sdram_rdy = 1'b0;
    scr_cs = 1'b1;
    #1;
    chk("late_rdy_ok", {31'd0, scr_ok}, 32'd0);
    chk("late_rdy_data", scr_data, 32'd0);
    wait_req("refetch_req", n, sa);
    chk("refetch_addr", {10'd0, sa}, 32'h000060);
    serve(0, 32'h13579BDF, 0, 0, 1'b0);
    chk("refetch_ok", {31'd0, scr_ok}, 32'd1);

    // Randomized run against the cache model
    scr_cs = 1'b0; obj_cs = 1'b0;
    do_reset();
    m_valid[0] = 0; m_valid[1] = 0;
    pool[0] = 18'h00000;
    pool[1] = 18'h3FFFF;
    for (int i = 2; i < 6; i++) pool[i] = 18'($urandom);
    for (int it = 0; it < 40; it++) begin
      int          c;
      logic [17:0] a;
      bit          hit;
      c = $urandom_range(0, 1);
      a = pool[$urandom_range(0, 5)];
      set_client(1 - c, 1'b0, 18'h0);
      set_client(c, 1'b1, a);
      #1;
      hit = m_valid[c] && (m_addr[c] == a);
      chk("rnd_ok", {31'd0, cur_ok(c)}, {31'd0, hit});
      if (hit) begin
        chk("rnd_hit_data", cur_data(c), m_data[c]);
        quiet("rnd_hit_noreq", 1);
      end else begin
        wait_req("rnd_req", n, sa);
        chk("rnd_req_latency", n, 32'd1);
        chk("rnd_addr", {10'd0, sa}, {10'd0, exp_addr(c, a)});
        d = $urandom;
        serve(c, d, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        chk("rnd_fill_ok", {31'd0, cur_ok(c)}, 32'd1);
        chk("rnd_fill_data", cur_data(c), d);
        m_valid[c] = 1'b1;
        m_addr[c]  = a;
        m_data[c]  = d;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtkiwi_gfxrom.md
JTKIWI_GFXROM -- requirements
Module: jtkiwi_gfxrom

Interface
REQ-001 SHALL have parameter SCR_OFFSET, default 22'h00_0000, SDRAM 16-bit-word base of tile graphics.
REQ-002 SHALL have parameter OBJ_OFFSET, default 22'h10_0000, SDRAM 16-bit-word base of sprite graphics.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports scr_cs input 1, scr_addr input [19:2], scr_data output 32, scr_ok output 1: tile client.
REQ-006 SHALL have ports obj_cs input 1, obj_addr input [19:2], obj_data output 32, obj_ok output 1: sprite client.
REQ-007 SHALL have ports sdram_req output 1, sdram_addr output 22 (16-bit-word address), sdram_ack input 1 (request accepted), sdram_rdy input 1 (data valid), sdram_din input 32.

Function
REQ-008 SHALL keep per client a latched address, 32-bit data register and valid flag.
REQ-009 SHALL drive x_ok = x_cs & valid & (x_addr == latched address), combinationally; x_data = data register.
REQ-010 SHALL flag a client as pending when x_cs is high and x_ok is low.
REQ-011 SHALL use FSM states IDLE, WAIT_ACK, WAIT_RDY.
REQ-012 IDLE: on any pending client, select one (REQ-022), latch its address, clear its valid, assert sdram_req registered next cycle, go WAIT_ACK.
REQ-013 sdram_addr SHALL equal OFFSET + {latched address, 1'b0}, modulo 2^22, held stable from req until rdy.
REQ-014 WAIT_ACK: sdram_req held high until the cycle sdram_ack is sampled high; then req low, go WAIT_RDY.
REQ-015 WAIT_RDY: on sdram_rdy, store sdram_din into the selected client's data register, set valid, go IDLE; x_ok rises the following cycle.
REQ-016 sdram_ack and sdram_rdy in the same cycle SHALL be treated as ack followed immediately by rdy (direct to IDLE, data stored).
REQ-017 Client address change during its fetch: fetch completes and stores data, ok stays low (mismatch), new fetch issued from IDLE.
REQ-018 Client cs dropping mid-fetch: fetch completes normally, valid set; no abort.
REQ-019 Minimum latency, new address to x_ok: 3 cycles with ack and rdy each returned one cycle after req.
REQ-020 sdram_ack/sdram_rdy outside WAIT_ACK/WAIT_RDY SHALL be ignored.

Reset
REQ-021 On rst: state IDLE, sdram_req 0, sdram_addr 0, both valid flags 0, data registers 0, scr_ok/obj_ok 0, arbitration pointer to scr; reset mid-fetch abandons the transaction.

Configuration
REQ-022 Macro JTKIWI_GFXROM_RR_EN defined: round-robin — after a served client, the other client wins the next simultaneous-pending tie; undefined: fixed priority, scr always wins ties.

Structure
REQ-023 Package jtkiwi_gfxrom_pkg SHALL hold the FSM state enum, client index constants (SCR=0, OBJ=1) and address width constants.
REQ-024 Per-client latch/compare/valid logic SHALL be sub-module jtkiwi_gfxrom_slot, instantiated twice.

Verification
REQ-025 scr_cs=1, scr_addr=18'h00010, ack/rdy one cycle after req, sdram_din=32'hDEADBEEF -> sdram_addr=22'h000020, scr_ok high 3 cycles after request, scr_data=32'hDEADBEEF.
REQ-026 Repeat same scr_addr after REQ-025 -> scr_ok immediate, no sdram_req.
REQ-027 scr and obj pending same cycle, obj_addr=18'h00004 -> scr served first, then obj at sdram_addr=22'h100008; with JTKIWI_GFXROM_RR_EN a second tie serves obj first.
REQ-028 scr_addr changed from 18'h00010 to 18'h00011 while in WAIT_RDY -> scr_ok stays 0, second fetch at 22'h000022, ok after its rdy.
REQ-029 Same-cycle ack and rdy with sdram_din=32'h12345678 -> data stored, FSM IDLE next cycle, client ok following cycle.
REQ-030 rst asserted in WAIT_RDY -> sdram_req 0 and both ok 0 immediately; late sdram_rdy ignored; post-reset request refetches.
